// File: rtl/bank_result_collector_if.sv
`default_nettype none
// =====================================================================
// Interface : bank_result_collector_if
// Brief     : Score-bank result lanes, query control and output FIFO port.
// Rev       : 1.0 - initial release
// =====================================================================
interface bank_result_collector_if #(
  parameter int SCORE_WIDTH = 12,
  parameter int ID_WIDTH    = 48,
  parameter int MODULES     = 2
);
  localparam int L  = 2 * MODULES;
  localparam int DW = ID_WIDTH + SCORE_WIDTH;

  logic [L*SCORE_WIDTH-1:0] results;
  logic [L*ID_WIDTH-1:0]    IDs;
  logic [L-1:0]             vld;
  logic                     query_start;
  logic                     query_done;
  logic [DW-1:0]            out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [DW-1:0]            max;
  logic                     vld_max;
  logic                     overflow;
  logic                     stray;

  modport master (
    output results, IDs, vld, query_start, query_done, out_ready,
    input  out_data, out_valid, max, vld_max, overflow, stray
  );

  modport slave (
    input  results, IDs, vld, query_start, query_done, out_ready,
    output out_data, out_valid, max, vld_max, overflow, stray
  );
endinterface
`default_nettype wire

// File: rtl/bank_result_collector.sv
`default_nettype none
// =====================================================================
// Module : bank_result_collector
// Brief  : Lane capture, round-robin serialisation into an output FIFO
//          and per-query best-score tracking with a query-level FSM.
// Rev    : 1.0 - initial release
// =====================================================================
module bank_result_collector #(
  parameter int SCORE_WIDTH = 12,
  parameter int ID_WIDTH    = 48,
  parameter int MODULES     = 2,
  parameter int FIFO_DEPTH  = 16
) (
  input logic                    clk,
  input logic                    rst,
  bank_result_collector_if.slave bus
);
  localparam int L  = 2 * MODULES;
  localparam int LW = (L > 1) ? $clog2(L) : 1;
  localparam int DW = ID_WIDTH + SCORE_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [SCORE_WIDTH-1:0] ZERO     = {1'b1, {(SCORE_WIDTH-1){1'b0}}};
  localparam logic [DW-1:0]          MAX_INIT = {{ID_WIDTH{1'b0}}, ZERO};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DRAIN  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t        state_q;
  logic [L-1:0]  hold_full_q, hold_full_d;
  logic [DW-1:0] hold_data_q [L];
  logic [DW-1:0] lane_data   [L];
  logic [LW-1:0] arb_ptr_q;
  logic [DW-1:0] fifo_mem_q  [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;
  logic [DW-1:0] max_q;
  logic          vld_max_q, overflow_q, stray_q;

  logic          capture_en, pop, push_ok, push, grant_valid;
  logic [LW-1:0] grant_idx, scan_idx;
  logic [DW-1:0] push_data;
  logic [L-1:0]  load, drop, drain;

  function automatic logic [LW-1:0] lane_add(input logic [LW-1:0] a, input int b);
    int s;
    s = (int'(a) + b) % L;
    return s[LW-1:0];
  endfunction

  assign capture_en = ((state_q == S_ACTIVE) || (state_q == S_DRAIN)) && !bus.query_start;
  assign pop        = (count_q != '0) && bus.out_ready;
  // A full FIFO still accepts a push when its head leaves on the same edge.
  assign push_ok    = (count_q < CW'(FIFO_DEPTH)) || pop;
  assign push       = grant_valid && push_ok && !bus.query_start;
  assign push_data  = hold_data_q[grant_idx];

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int i = 0; i < L; i++) begin
      scan_idx = lane_add(arb_ptr_q, i);
      if (!grant_valid && hold_full_q[scan_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  for (genvar k = 0; k < L; k++) begin : g_lane
    assign lane_data[k] = {bus.IDs[k*ID_WIDTH +: ID_WIDTH],
                           bus.results[k*SCORE_WIDTH +: SCORE_WIDTH]};
    assign drain[k]     = push && (grant_idx == LW'(k));
    assign load[k]      = capture_en && bus.vld[k] && (!hold_full_q[k] || drain[k]);
    assign drop[k]      = capture_en && bus.vld[k] && hold_full_q[k] && !drain[k];
  end

  assign hold_full_d = (hold_full_q & ~drain) | load;

  always_ff @(posedge clk) begin
    if (rst || bus.query_start) begin
      hold_full_q <= '0;
      arb_ptr_q   <= '0;
    end else begin
      hold_full_q <= hold_full_d;
      if (push) begin
        arb_ptr_q <= lane_add(grant_idx, 1);
      end
    end
    for (int k = 0; k < L; k++) begin
      if (load[k]) begin
        hold_data_q[k] <= lane_data[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        fifo_mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q             <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      max_q      <= MAX_INIT;
      vld_max_q  <= 1'b0;
      overflow_q <= 1'b0;
      stray_q    <= 1'b0;
    end else if (bus.query_start) begin
      state_q    <= S_ACTIVE;
      max_q      <= MAX_INIT;
      vld_max_q  <= 1'b0;
      overflow_q <= 1'b0;
      stray_q    <= 1'b0;
    end else begin
      // Biased scores order correctly as unsigned; ties keep the earlier result.
      if (push && (push_data[SCORE_WIDTH-1:0] > max_q[SCORE_WIDTH-1:0])) begin
        max_q <= push_data;
      end
      if (|drop) begin
        overflow_q <= 1'b1;
      end
      if (((state_q == S_IDLE) || (state_q == S_DONE)) && (|bus.vld)) begin
        stray_q <= 1'b1;
      end
      case (state_q)
        S_IDLE:   ;
        S_ACTIVE: if (bus.query_done) state_q <= S_DRAIN;
        S_DRAIN: begin
          if ((hold_full_q == '0) && (load == '0)) begin
            state_q   <= S_DONE;
            vld_max_q <= 1'b1;
          end
        end
        S_DONE:   ;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.out_data  = fifo_mem_q[rd_ptr_q];
  assign bus.out_valid = (count_q != '0);
  assign bus.max       = max_q;
  assign bus.vld_max   = vld_max_q;
  assign bus.overflow  = overflow_q;
  assign bus.stray     = stray_q;
endmodule
`default_nettype wire

// File: tb/tb_bank_result_collector.sv
`default_nettype none
// =====================================================================
// Module : tb_bank_result_collector
// Brief  : Randomised and directed scoreboard bench for the collector.
// Rev    : 1.0 - initial release
// =====================================================================
module tb_bank_result_collector;
  localparam int SW    = 12;
  localparam int IW    = 48;
  localparam int M     = 2;
  localparam int L     = 2 * M;
  localparam int DEPTH = 4;
  localparam int DW    = IW + SW;
  localparam logic [SW-1:0] ZERO = 12'h800;
  localparam logic [DW-1:0] MAX0 = {48'h0, 12'h800};
  localparam int S_IDLE = 0, S_ACTIVE = 1, S_DRAIN = 2, S_DONE = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bank_result_collector_if #(.SCORE_WIDTH(SW), .ID_WIDTH(IW), .MODULES(M)) bus();

  bank_result_collector #(
    .SCORE_WIDTH(SW), .ID_WIDTH(IW), .MODULES(M), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Reference model: slots, FIFO occupancy and query status as plain variables
  logic [DW-1:0] exp_q[$];
  int            mcnt = 0;
  int            m_ptr = 0;
  int            m_state = S_IDLE;
  bit            m_full[L];
  logic [DW-1:0] m_data[L];
  logic [DW-1:0] m_max = MAX0;
  bit            m_vmax = 0, m_ovf = 0, m_stray = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic model_clear_query();
    for (int k = 0; k < L; k++) m_full[k] = 0;
    m_ptr = 0; m_max = MAX0; m_vmax = 0; m_ovf = 0; m_stray = 0;
  endtask

  task automatic model_step();
    bit pop, push, was_empty, any_load;
    int g, idx;
    if (rst) begin
      exp_q.delete(); mcnt = 0; m_state = S_IDLE; model_clear_query();
      return;
    end
    pop = (mcnt > 0) && bus.out_ready;
    if (bus.query_start) begin
      model_clear_query();
      m_state = S_ACTIVE;
    end else begin
      was_empty = 1; g = -1;
      for (int off = 0; off < L; off++) begin
        idx = (m_ptr + off) % L;
        if (m_full[idx]) begin
          was_empty = 0;
          if (g < 0) g = idx;
        end
      end
      push = (g >= 0) && ((mcnt < DEPTH) || pop);
      if (push) begin
        exp_q.push_back(m_data[g]);
        mcnt++;
        m_full[g] = 0;
        m_ptr = (g + 1) % L;
        if (m_data[g][SW-1:0] > m_max[SW-1:0]) m_max = m_data[g];
      end
      any_load = 0;
      for (int k = 0; k < L; k++) begin
        if (bus.vld[k]) begin
          if (m_state == S_ACTIVE || m_state == S_DRAIN) begin
            if (m_full[k]) m_ovf = 1;
            else begin
              m_full[k] = 1;
              m_data[k] = {bus.IDs[k*IW +: IW], bus.results[k*SW +: SW]};
              any_load = 1;
            end
          end else m_stray = 1;
        end
      end
      if (m_state == S_ACTIVE && bus.query_done) m_state = S_DRAIN;
      else if (m_state == S_DRAIN && was_empty && !any_load) begin
        m_state = S_DONE;
        m_vmax = 1;
      end
    end
    if (pop) mcnt--;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Monitor: compares every handshake and the status outputs mid-cycle
  initial begin
    forever begin
      @(negedge clk);
      check("out_valid", 128'(bus.out_valid), 128'(mcnt != 0));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL out_data_unexpected actual=%0h required=no_entry", bus.out_data);
        end else begin
          check("out_data", 128'(bus.out_data), 128'(exp_q.pop_front()));
        end
      end
      check("max", 128'(bus.max), 128'(m_max));
      check("vld_max", 128'(bus.vld_max), 128'(m_vmax));
      check("overflow", 128'(bus.overflow), 128'(m_ovf));
      check("stray", 128'(bus.stray), 128'(m_stray));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_lane(input int k, input logic [IW-1:0] id, input logic [SW-1:0] sc);
    bus.IDs[k*IW +: IW]     = id;
    bus.results[k*SW +: SW] = sc;
  endtask

  task automatic pulse_vld(input logic [L-1:0] v);
    bus.vld = v; tick(); bus.vld = '0;
  endtask

  task automatic start_query();
    bus.query_start = 1'b1; tick(); bus.query_start = 1'b0;
  endtask

  task automatic end_query();
    bus.query_done = 1'b1; tick(); bus.query_done = 1'b0;
  endtask

  task automatic wait_done(input bit rnd_ready);
    int n = 0;
    while (!bus.vld_max && n < 200) begin
      if (rnd_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
      tick();
      n++;
    end
    checks++;
    if (!bus.vld_max) begin
      errors++;
      $display("FAIL done_timeout actual=vld_max_0_after_%0d_cycles required=1", n);
    end
  endtask

  initial begin
    int n;
    bus.vld = '0; bus.results = '0; bus.IDs = '0;
    bus.query_start = 1'b0; bus.query_done = 1'b0; bus.out_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_out_valid", 128'(bus.out_valid), 128'(0));
    check("rst_max", 128'(bus.max), 128'(MAX0));
    check("rst_vld_max", 128'(bus.vld_max), 128'(0));

    // Single result with explicit 2-cycle latency
    bus.out_ready = 1'b1;
    start_query();
    set_lane(0, 48'h1, ZERO + 12'd5);
    pulse_vld(4'b0001);
    check("single_lat_early", 128'(bus.out_valid), 128'(0));
    end_query();
    check("single_lat", 128'(bus.out_valid), 128'(1));
    check("single_data", 128'(bus.out_data), 128'({48'h1, ZERO + 12'd5}));
    wait_done(0);
    check("single_max", 128'(bus.max), 128'({48'h1, ZERO + 12'd5}));

    // Burst with tie: lane 1 arrives before lane 2, so it stays the best
    start_query();
    set_lane(0, 48'hA0, ZERO + 12'd3);
    set_lane(1, 48'hA1, ZERO + 12'd9);
    set_lane(2, 48'hA2, ZERO + 12'd9);
    set_lane(3, 48'hA3, ZERO + 12'd1);
    pulse_vld(4'hF);
    end_query();
    wait_done(0);
    check("tie_max", 128'(bus.max), 128'({48'hA1, ZERO + 12'd9}));

    // Overflow into a stalled FIFO, then backpressure with toggling ready
    repeat (3) tick();
    bus.out_ready = 1'b0;
    start_query();
    for (int i = 0; i < 6; i++) begin
      set_lane(0, 48'hB0 + 48'(i), ZERO + 12'(i));
      bus.vld = 4'b0001;
      tick();
    end
    bus.vld = '0;
    check("ovf_sticky", 128'(bus.overflow), 128'(1));
    for (int k = 1; k < L; k++) set_lane(k, 48'hC0 + 48'(k), ZERO - 12'd1);
    pulse_vld(4'b1110);
    for (int i = 0; i < 12; i++) begin
      bus.out_ready = (i % 2 == 0);
      tick();
    end
    bus.out_ready = 1'b1;
    end_query();
    wait_done(0);
    check("ovf_max", 128'(bus.max), 128'({48'hB4, ZERO + 12'd4}));

    // Empty query finishes two cycles after query_done; late vld is stray
    start_query();
    end_query();
    check("empty_not_yet", 128'(bus.vld_max), 128'(0));
    tick();
    check("empty_done", 128'(bus.vld_max), 128'(1));
    check("empty_max", 128'(bus.max), 128'(MAX0));
    pulse_vld(4'b0100);
    check("done_stray", 128'(bus.stray), 128'(1));

    // Reset in the middle of a burst
    start_query();
    bus.out_ready = 1'b0;
    pulse_vld(4'hF);
    bus.vld = 4'hF; rst = 1'b1;
    tick();
    rst = 1'b0; bus.vld = '0;
    check("rst_mid_out_valid", 128'(bus.out_valid), 128'(0));
    check("rst_mid_vld_max", 128'(bus.vld_max), 128'(0));
    pulse_vld(4'b0001);
    check("rst_idle_stray", 128'(bus.stray), 128'(1));

    // Randomised queries
    for (int q = 0; q < 30; q++) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      start_query();
      n = $urandom_range(2, 16);
      for (int c = 0; c < n; c++) begin
        for (int k = 0; k < L; k++)
          set_lane(k, {16'($urandom), $urandom}, ZERO - 12'd8 + 12'($urandom_range(0, 15)));
        bus.vld = L'($urandom);
        bus.out_ready = ($urandom_range(0, 3) != 0);
        tick();
      end
      bus.vld = '0;
      end_query();
      wait_done(1);
      if ($urandom_range(0, 3) == 0) pulse_vld(L'($urandom));
    end

    bus.out_ready = 1'b1;
    repeat (DEPTH + 4) tick();
    check("final_fifo_empty", 128'(exp_q.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/bank_result_collector.md
# bank_result_collector

Downstream consumer of the score bank's result lanes: captures the 2*MODULES per-lane scores with their sequence IDs, serialises them into a ready/valid output FIFO, and tracks the per-query best score and its ID. A query-level FSM reports the final maximum once every captured result has been accounted for. Sits between the score bank outputs and the host readback/DMA path.

## Interface
- SCORE_WIDTH, 12, biased score width; must match the bank.
- ID_WIDTH, 48, target sequence ID width.
- MODULES, 2, scoring modules in the bank; lanes L = 2*MODULES.
- FIFO_DEPTH, 16, output FIFO entries; power of two, at least 2.
- ZERO, 2**(SCORE_WIDTH-1), biased zero score.
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- results  in  L*SCORE_WIDTH  lane k score at bits [k*SCORE_WIDTH +: SCORE_WIDTH].
- IDs  in  L*ID_WIDTH  lane k ID at bits [k*ID_WIDTH +: ID_WIDTH].
- vld  in  L  lane k result valid for one cycle.
- query_start  in  1  one-cycle pulse: a new query begins.
- query_done  in  1  one-cycle pulse: the bank has issued every result for the query.
- out_data  out  ID_WIDTH+SCORE_WIDTH  FIFO head, {ID, score}.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts the head this cycle.
- max  out  ID_WIDTH+SCORE_WIDTH  {ID, score} of the best result of the current query.
- vld_max  out  1  max is final; held until the next query_start or rst.
- overflow  out  1  sticky: at least one result was dropped this query.
- stray  out  1  sticky: vld seen while IDLE or DONE.

## Operation
- Capture: each lane has a one-entry holding register. In ACTIVE or DRAIN, vld[k]=1 loads lane k's {ID, score}.
  - If the holding register is full and not being drained this cycle, the new result is dropped, the old one is kept, and overflow is set.
  - A same-cycle drain plus new arrival refills the holding register and does not count as overflow.
- Arbiter: round-robin across full holding registers. Search starts one lane after the last lane served; the pointer resets to lane 0. At most one entry moves per cycle.
  - A push is allowed when FIFO count < FIFO_DEPTH, or when the FIFO is full and the head pops this cycle.
  - If no push is allowed, the holding registers stall with their contents intact.
- Max update: happens on the same edge as the push.
  - Scores are compared unsigned; the bias makes this correct.
  - Strictly greater replaces; on a tie the earlier result is kept.
- FSM:
  - IDLE: query_start -> ACTIVE.
  - ACTIVE: query_done -> DRAIN.
  - DRAIN: when all holding registers are empty and none is loading this cycle -> DONE.
  - DONE: vld_max = 1. query_start -> ACTIVE.
- query_start in any state clears all holding registers, max (to {0, ZERO}), overflow, stray and vld_max, and resets the arbiter pointer. The FIFO contents are kept. query_start wins over a simultaneous query_done.
- query_done outside ACTIVE is ignored.
- A query with no results ends with max = {0, ZERO}.
- Reset values: out_valid 0, max {0, ZERO}, vld_max 0, overflow 0, stray 0, FIFO empty, state IDLE.

## Timing
- vld in cycle t: holding register is loaded at the end of t. If selected, the result is pushed and max is updated at the end of t+1. out_valid is high in t+2 if the FIFO was empty.
- Capture-to-output latency is 2 cycles minimum. An L-lane burst drains in L cycles.
- FIFO handshake: a pop occurs when out_valid && out_ready. out_data is stable while out_valid=1 and out_ready=0.
- DRAIN to DONE takes at least one cycle after query_done. vld_max rises one cycle after the last holding register empties.
- rst asserted mid-query takes effect on the next edge and discards all state, including the FIFO.

## Test plan
- Single result: query_start; lane 0 vld with score ZERO+5, ID 0x1; query_done -> out_data {0x1, ZERO+5} in t+2; vld_max=1 with max={0x1, ZERO+5}.
- Burst and tie: all 4 lanes valid in one cycle with scores ZERO+{3,9,9,1} -> 4 FIFO entries, in lane order 0,1,2,3; max ID = lane 1's ID.
- Overflow: out_ready=0, FIFO_DEPTH=2, lane 0 valid 4 consecutive cycles -> 2 entries in FIFO, 1 in holding register; overflow=1 after the 4th vld; no entry is corrupted.
- Backpressure: FIFO full, out_ready toggling 1/0 -> entries popped in order with no duplicates; push occurs only on pop cycles.
- Empty query: query_start, then query_done with no vld -> DONE two cycles later, max={0, ZERO}; vld during DONE -> stray=1.
- Reset: rst mid-burst -> next cycle out_valid=0, vld_max=0, state IDLE; a following query behaves normally.
